// File: rtl/huff_bit_packer_if.sv
// huff_bit_packer_if
//   Handshake bundle between a Huffman code producer, the bit packer and the
//   word consumer.
//   master : code producer / word consumer side (drives codes, flush, out_ready)
//   slave  : the packer (drives in_ready, output word, status)
//   Signals:
//     in_valid/in_ready      code handshake
//     code_value/code_mask   code bits, low-aligned contiguous mask
//     flush                  drain request
//     out_valid/out_ready    word handshake
//     out_data/out_nbits     packed word (oldest bit in MSB), valid bit count
//     out_last               final word of a flush
//     flush_done             one-cycle flush completion pulse
//     total_bits             running count of accepted code bits
interface huff_bit_packer_if #(
    parameter int WORD_W     = 16,
    parameter int MAX_CODE_W = 15
);
    localparam int NB_W = $clog2(WORD_W + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [MAX_CODE_W-1:0] code_value;
    logic [MAX_CODE_W-1:0] code_mask;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_data;
    logic [NB_W-1:0]       out_nbits;
    logic                  out_last;
    logic                  flush_done;
    logic [31:0]           total_bits;

    modport master (
        output in_valid, code_value, code_mask, flush, out_ready,
        input  in_ready, out_valid, out_data, out_nbits, out_last,
               flush_done, total_bits
    );

    modport slave (
        input  in_valid, code_value, code_mask, flush, out_ready,
        output in_ready, out_valid, out_data, out_nbits, out_last,
               flush_done, total_bits
    );
endinterface

// File: rtl/huff_bit_packer.sv
// huff_bit_packer
//   Concatenates variable-length Huffman codes MSB-first into a continuous
//   bitstream and emits fixed WORD_W-bit words. A flush drains the trailing
//   partial word (zero padded, out_last=1) and pulses flush_done.
//   Ports:
//     clk    single clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    huff_bit_packer_if.slave (code in, word out, status)
module huff_bit_packer #(
    parameter int WORD_W     = 16,
    parameter int MAX_CODE_W = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    huff_bit_packer_if.slave   bus
);
    localparam int ACC_W  = WORD_W + MAX_CODE_W - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NB_W   = $clog2(WORD_W + 1);
    localparam int LEN_W  = $clog2(MAX_CODE_W + 1);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [ACC_W-1:0]  acc;
    logic [FILL_W-1:0] fill;
    logic [1:0]        state;
    logic [31:0]       total;

    logic [LEN_W-1:0]  len;
    logic [ACC_W-1:0]  code_ext;
    logic [FILL_W-1:0] shamt;
    logic              accept;
    logic              pop;

    // Code length is the popcount of the (contiguous) mask.
    always_comb begin
        len = '0;
        for (int i = 0; i < MAX_CODE_W; i++)
            len = len + LEN_W'(bus.code_mask[i]);
    end

    // Masking drops value bits above len. The code is shifted so that its top
    // bit lands just below the current fill. Accept only happens with
    // fill < WORD_W, so shamt cannot go negative.
    assign code_ext = ACC_W'(bus.code_value & bus.code_mask);
    assign shamt    = FILL_W'(ACC_W) - fill - FILL_W'(len);

    assign bus.in_ready   = (state == RUN) && (fill < FILL_W'(WORD_W));
    assign bus.out_valid  = (fill >= FILL_W'(WORD_W)) || ((state == FLUSH) && (fill != '0));
    assign bus.out_data   = acc[ACC_W-1 -: WORD_W];
    assign bus.out_nbits  = (fill >= FILL_W'(WORD_W)) ? NB_W'(WORD_W) : NB_W'(fill);
    assign bus.out_last   = (state == FLUSH) && (fill <= FILL_W'(WORD_W)) && bus.out_valid;
    assign bus.flush_done = (state == DONE);
    assign bus.total_bits = total;

    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc   <= '0;
            fill  <= '0;
            state <= RUN;
            total <= '0;
        end else begin
            // Accept needs fill < WORD_W and no flush in progress; pop needs
            // fill >= WORD_W or FLUSH. The two never coincide.
            if (accept) begin
                acc   <= acc | (code_ext << shamt);
                fill  <= fill + FILL_W'(len);
                total <= total + 32'(len);
            end else if (pop) begin
                acc  <= acc << WORD_W;
                fill <= fill - FILL_W'(bus.out_nbits);
            end

            case (state)
                RUN:     if (bus.flush) state <= FLUSH;
                // Empty buffer finishes at once; otherwise leave on the last pop.
                FLUSH:   if ((fill == '0) || (pop && bus.out_last)) state <= DONE;
                DONE:    state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_huff_bit_packer.sv
module tb_huff_bit_packer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    huff_bit_packer_if #(.WORD_W(8),  .MAX_CODE_W(15)) bus8 ();
    huff_bit_packer_if #(.WORD_W(16), .MAX_CODE_W(15)) bus16 ();

    huff_bit_packer #(.WORD_W(8),  .MAX_CODE_W(15)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    huff_bit_packer #(.WORD_W(16), .MAX_CODE_W(15)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_total16 = 0;

    typedef struct {
        logic [15:0] data;
        int          nb;
        logic        last;
        int          c;
    } word_t;

    word_t w8_q[$];
    word_t w16_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word transfer, sampled between the driving negedge and
    // the committing posedge.
    always begin
        word_t w;
        @(negedge clk);
        #1;
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            w.data = {8'h00, bus8.out_data}; w.nb = int'(bus8.out_nbits);
            w.last = bus8.out_last; w.c = cyc;
            w8_q.push_back(w);
        end
        if (rst_n && bus16.out_valid && bus16.out_ready) begin
            w.data = bus16.out_data; w.nb = int'(bus16.out_nbits);
            w.last = bus16.out_last; w.c = cyc;
            w16_q.push_back(w);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        bus8.in_valid = 0;  bus8.code_value = '0;  bus8.code_mask = '0;
        bus8.flush = 0;     bus8.out_ready = 0;
        bus16.in_valid = 0; bus16.code_value = '0; bus16.code_mask = '0;
        bus16.flush = 0;    bus16.out_ready = 0;
    endtask

    // Present one code at the current negedge and hold it until accepted.
    task automatic send8(input logic [14:0] v, input logic [14:0] m, output bit ok);
        ok = 0;
        bus8.in_valid = 1; bus8.code_value = v; bus8.code_mask = m;
        for (int k = 0; k < 50; k++) begin
            if (bus8.in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus8.in_valid = 0;
    endtask

    task automatic send16(input logic [14:0] v, input logic [14:0] m, output bit ok);
        ok = 0;
        bus16.in_valid = 1; bus16.code_value = v; bus16.code_mask = m;
        for (int k = 0; k < 50; k++) begin
            if (bus16.in_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        bus16.in_valid = 0;
    endtask

    task automatic test_reset();
        idle_all();
        rst_n = 0;
        repeat (2) @(negedge clk);
        tests++; if (bus16.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
        tests++; if (bus16.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus16.in_ready); end
        tests++; if (bus16.total_bits !== 32'd0) begin fails++; $display("FAIL reset_total: got %0d want 0", bus16.total_bits); end
        tests++; if (bus16.flush_done !== 1'b0) begin fails++; $display("FAIL reset_flush_done: got %b want 0", bus16.flush_done); end
        tests++; if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin fails++; $display("FAIL reset_w8: valid %b ready %b want 0 1", bus8.out_valid, bus8.in_ready); end
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_word8();
        bit ok;
        bit seen;
        int done_c;
        w8_q.delete();
        bus8.out_ready = 1;
        send8(15'h5, 15'h7, ok); tests++; if (!ok) begin fails++; $display("FAIL w8_send0: timeout"); end
        send8(15'h1, 15'h3, ok); tests++; if (!ok) begin fails++; $display("FAIL w8_send1: timeout"); end
        send8(15'h6, 15'h7, ok); tests++; if (!ok) begin fails++; $display("FAIL w8_send2: timeout"); end
        send8(15'h1, 15'h1, ok); tests++; if (!ok) begin fails++; $display("FAIL w8_send3: timeout"); end
        repeat (3) @(negedge clk);
        tests++;
        if (w8_q.size() != 1) begin
            fails++; $display("FAIL w8_word_count: got %0d want 1", w8_q.size());
        end else if (w8_q[0].data !== 16'h00AE || w8_q[0].nb != 8 || w8_q[0].last !== 1'b0) begin
            fails++; $display("FAIL w8_word: got %h/%0d/%b want 00ae/8/0", w8_q[0].data, w8_q[0].nb, w8_q[0].last);
        end
        bus8.flush = 1;
        @(negedge clk);
        bus8.flush = 0;
        seen = 0; done_c = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus8.flush_done === 1'b1) begin seen = 1; done_c = cyc; break; end
            @(negedge clk);
        end
        tests++; if (!seen) begin fails++; $display("FAIL w8_flush_done: timeout"); end
        tests++;
        if (w8_q.size() != 2) begin
            fails++; $display("FAIL w8_last_count: got %0d want 2", w8_q.size());
        end else begin
            if (w8_q[1].data !== 16'h0080 || w8_q[1].nb != 1 || w8_q[1].last !== 1'b1) begin
                fails++; $display("FAIL w8_last_word: got %h/%0d/%b want 0080/1/1", w8_q[1].data, w8_q[1].nb, w8_q[1].last);
            end
            tests++;
            if (done_c != w8_q[1].c + 1) begin
                fails++; $display("FAIL w8_done_timing: got cycle %0d want %0d", done_c, w8_q[1].c + 1);
            end
        end
        tests++; if (bus8.total_bits !== 32'd9) begin fails++; $display("FAIL w8_total: got %0d want 9", bus8.total_bits); end
        @(negedge clk);
        tests++; if (bus8.flush_done !== 1'b0) begin fails++; $display("FAIL w8_done_width: got %b want 0", bus8.flush_done); end
        bus8.out_ready = 0;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit held;
        bit seen;
        w16_q.delete();
        bus16.out_ready = 0;
        send16(15'h7FFF, 15'h7FFF, ok); tests++; if (!ok) begin fails++; $display("FAIL bp_send0: timeout"); end
        send16(15'h7FFF, 15'h7FFF, ok); tests++; if (!ok) begin fails++; $display("FAIL bp_send1: timeout"); end
        exp_total16 += 30;
        held = 1;
        for (int k = 0; k < 10; k++) begin
            if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1 || bus16.out_data !== 16'hFFFF ||
                bus16.out_nbits !== 5'd16 || bus16.out_last !== 1'b0) held = 0;
            @(negedge clk);
        end
        tests++; if (!held) begin fails++; $display("FAIL bp_hold: got data %h nbits %0d ready %b want ffff 16 0", bus16.out_data, bus16.out_nbits, bus16.in_ready); end
        bus16.out_ready = 1;
        @(negedge clk);
        bus16.out_ready = 0;
        tests++; if (w16_q.size() != 1) begin fails++; $display("FAIL bp_pop_count: got %0d want 1", w16_q.size()); end
        tests++; if (bus16.out_nbits !== 5'd14) begin fails++; $display("FAIL bp_fill: got %0d want 14", bus16.out_nbits); end
        tests++; if (bus16.in_ready !== 1'b1 || bus16.out_valid !== 1'b0) begin fails++; $display("FAIL bp_after_pop: ready %b valid %b want 1 0", bus16.in_ready, bus16.out_valid); end
        bus16.out_ready = 1;
        bus16.flush = 1;
        @(negedge clk);
        bus16.flush = 0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus16.flush_done === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        tests++; if (!seen) begin fails++; $display("FAIL bp_flush_done: timeout"); end
        tests++;
        if (w16_q.size() != 2) begin
            fails++; $display("FAIL bp_drain_count: got %0d want 2", w16_q.size());
        end else if (w16_q[1].data !== 16'hFFFC || w16_q[1].nb != 14 || w16_q[1].last !== 1'b1) begin
            fails++; $display("FAIL bp_drain_word: got %h/%0d/%b want fffc/14/1", w16_q[1].data, w16_q[1].nb, w16_q[1].last);
        end
        tests++; if (bus16.total_bits !== 32'(exp_total16)) begin fails++; $display("FAIL bp_total: got %0d want %0d", bus16.total_bits, exp_total16); end
        @(negedge clk);
        bus16.out_ready = 0;
    endtask

    task automatic test_zero_len();
        bit quiet;
        tests++; if (bus16.in_ready !== 1'b1) begin fails++; $display("FAIL zl_ready: got %b want 1", bus16.in_ready); end
        bus16.in_valid = 1; bus16.code_value = 15'h7FFF; bus16.code_mask = 15'h0000;
        @(negedge clk);
        bus16.in_valid = 0;
        tests++; if (bus16.out_nbits !== 5'd0) begin fails++; $display("FAIL zl_fill: got %0d want 0", bus16.out_nbits); end
        tests++; if (bus16.total_bits !== 32'(exp_total16)) begin fails++; $display("FAIL zl_total: got %0d want %0d", bus16.total_bits, exp_total16); end
        quiet = 1;
        for (int k = 0; k < 4; k++) begin
            if (bus16.out_valid !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        tests++; if (!quiet) begin fails++; $display("FAIL zl_valid: out_valid rose, want 0"); end
    endtask

    task automatic test_flush_empty();
        bus16.flush = 1;
        @(negedge clk);
        bus16.flush = 0;
        tests++; if (bus16.out_valid !== 1'b0 || bus16.flush_done !== 1'b0 || bus16.in_ready !== 1'b0) begin
            fails++; $display("FAIL fe_cycle1: valid %b done %b ready %b want 0 0 0", bus16.out_valid, bus16.flush_done, bus16.in_ready); end
        @(negedge clk);
        tests++; if (bus16.flush_done !== 1'b1 || bus16.out_valid !== 1'b0) begin
            fails++; $display("FAIL fe_done: done %b valid %b want 1 0", bus16.flush_done, bus16.out_valid); end
        @(negedge clk);
        tests++; if (bus16.flush_done !== 1'b0 || bus16.in_ready !== 1'b1) begin
            fails++; $display("FAIL fe_back_to_run: done %b ready %b want 0 1", bus16.flush_done, bus16.in_ready); end
    endtask

    task automatic test_flush_accept();
        bus16.out_ready = 1;
        tests++; if (bus16.in_ready !== 1'b1) begin fails++; $display("FAIL fa_ready: got %b want 1", bus16.in_ready); end
        bus16.in_valid = 1; bus16.code_value = 15'h3; bus16.code_mask = 15'h3; bus16.flush = 1;
        @(negedge clk);
        bus16.in_valid = 0; bus16.flush = 0;
        exp_total16 += 2;
        tests++; if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'hC000 || bus16.out_nbits !== 5'd2 || bus16.out_last !== 1'b1) begin
            fails++; $display("FAIL fa_word: valid %b data %h nbits %0d last %b want 1 c000 2 1",
                              bus16.out_valid, bus16.out_data, bus16.out_nbits, bus16.out_last); end
        @(negedge clk);
        tests++; if (bus16.flush_done !== 1'b1) begin fails++; $display("FAIL fa_done: got %b want 1", bus16.flush_done); end
        @(negedge clk);
        bus16.out_ready = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit quiet;
        bus16.out_ready = 0;
        send16(15'h3FF, 15'h3FF, ok); tests++; if (!ok) begin fails++; $display("FAIL rm_send: timeout"); end
        bus16.flush = 1;
        @(negedge clk);
        bus16.flush = 0;
        tests++; if (bus16.out_valid !== 1'b1 || bus16.out_last !== 1'b1 || bus16.out_nbits !== 5'd10) begin
            fails++; $display("FAIL rm_pre: valid %b last %b nbits %0d want 1 1 10", bus16.out_valid, bus16.out_last, bus16.out_nbits); end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_total16 = 0;
        tests++; if (bus16.out_valid !== 1'b0 || bus16.out_nbits !== 5'd0 || bus16.in_ready !== 1'b1 || bus16.total_bits !== 32'd0) begin
            fails++; $display("FAIL rm_post: valid %b nbits %0d ready %b total %0d want 0 0 1 0",
                              bus16.out_valid, bus16.out_nbits, bus16.in_ready, bus16.total_bits); end
        quiet = 1;
        for (int k = 0; k < 5; k++) begin
            if (bus16.flush_done !== 1'b0 || bus16.out_valid !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        tests++; if (!quiet) begin fails++; $display("FAIL rm_quiet: flush_done or out_valid rose after reset"); end
    endtask

    // Reference model: a plain FIFO of bits, oldest first.
    task automatic test_random();
        bit q[$];
        bit flushing;
        bit draining;
        bit done_seen;
        bit acc_now, pop_now;
        int len;
        int n;
        logic [15:0] exp_word;
        logic [14:0] v;
        for (int round = 0; round < 4; round++) begin
            flushing = 0; draining = 0; done_seen = 0;
            for (int t = 0; t < 400 && !done_seen; t++) begin
                // check current outputs against the model
                tests++;
                if (bus16.out_valid !== ((q.size() >= 16) || (flushing && q.size() > 0))) begin
                    fails++; $display("FAIL rnd_valid: got %b model bits %0d flushing %b", bus16.out_valid, q.size(), flushing);
                end
                if (bus16.out_valid === 1'b1) begin
                    n = (q.size() < 16) ? q.size() : 16;
                    exp_word = '0;
                    for (int i = 0; i < n; i++) exp_word[15-i] = q[i];
                    tests++;
                    if (bus16.out_data !== exp_word || int'(bus16.out_nbits) != n ||
                        bus16.out_last !== (flushing && q.size() <= 16)) begin
                        fails++; $display("FAIL rnd_word: got %h/%0d/%b want %h/%0d/%b", bus16.out_data, bus16.out_nbits,
                                          bus16.out_last, exp_word, n, flushing && q.size() <= 16);
                    end
                end
                if (bus16.flush_done === 1'b1) begin
                    done_seen = 1;
                    tests++; if (!flushing || q.size() != 0) begin fails++; $display("FAIL rnd_done: flushing %b bits left %0d want 1 0", flushing, q.size()); end
                end
                if (!done_seen) begin
                    // new stimulus for the coming edge
                    len = $urandom_range(0, 15);
                    v = 15'($urandom);
                    bus16.in_valid   = !draining && ($urandom_range(0, 3) != 0);
                    bus16.code_value = v;
                    bus16.code_mask  = 15'((1 << len) - 1);
                    bus16.out_ready  = ($urandom_range(0, 2) != 0);
                    bus16.flush      = !draining && (t == 150 + round * 20);
                    acc_now = bus16.in_valid && bus16.in_ready;
                    pop_now = bus16.out_valid && bus16.out_ready;
                    if (pop_now) begin
                        n = (q.size() < 16) ? q.size() : 16;
                        for (int i = 0; i < n; i++) void'(q.pop_front());
                    end
                    if (acc_now) begin
                        for (int i = len - 1; i >= 0; i--) q.push_back(v[i]);
                        exp_total16 += len;
                    end
                    if (bus16.flush && bus16.in_ready !== 1'b0) begin
                        flushing = 1; draining = 1;
                    end else if (bus16.flush) begin
                        // RUN with in_ready=0 (fill >= WORD_W) still takes the flush
                        flushing = 1; draining = 1;
                    end
                    @(negedge clk);
                    bus16.flush = 0;
                end
            end
            tests++; if (!done_seen) begin fails++; $display("FAIL rnd_timeout: round %0d never completed flush", round); end
            tests++; if (bus16.total_bits !== 32'(exp_total16)) begin fails++; $display("FAIL rnd_total: got %0d want %0d", bus16.total_bits, exp_total16); end
            bus16.in_valid = 0; bus16.out_ready = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        idle_all();
        rst_n = 0;
        @(negedge clk);
        test_reset();
        test_word8();
        test_backpressure();
        test_zero_len();
        test_flush_empty();
        test_flush_accept();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/huff_bit_packer.md
Name: huff_bit_packer

Overview:
- Sequential stage directly downstream of huff_encoder.
- Accepts one Huffman code per handshake, as a value plus a contiguous low-aligned mask in the same 15-bit format huff_encoder produces (encoded_value / encoded_mask).
- Concatenates codes MSB-first into a continuous bitstream and emits fixed-width words over a valid/ready interface.
- A flush request drains the final partial word, zero-padded, marked last.

Parameters:
- WORD_W, 16, output word width in bits; legal range 8..32.
- MAX_CODE_W, 15, code width; equals the upstream 2*6+3 encoding width.

Ports:
- clk, input, 1, single clock; all state changes on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, code present.
- in_ready, output, 1, packer accepts code this cycle.
- code_value, input, MAX_CODE_W, code bits; bit len-1 is transmitted first.
- code_mask, input, MAX_CODE_W, contiguous ones from bit 0; len = popcount.
- flush, input, 1, request to drain the partial word after all accepted codes.
- out_valid, output, 1, output word valid.
- out_ready, input, 1, consumer accepts word.
- out_data, output, WORD_W, packed bits; the oldest bit is in the MSB.
- out_nbits, output, clog2(WORD_W+1), valid bits in out_data (WORD_W except on the last partial word).
- out_last, output, 1, final word of a flush.
- flush_done, output, 1, one-cycle pulse when the flush completes.
- total_bits, output, 32, running count of code bits accepted since reset; wraps modulo 2^32.

Behaviour:
- State:
  - acc: WORD_W+MAX_CODE_W-1 bits, left-aligned queue; the oldest bit is at the MSB.
  - fill: 0..WORD_W+MAX_CODE_W-1.
  - FSM: RUN, FLUSH, DONE.
- Reset (rst_n=0 at an edge):
  - acc=0, fill=0, FSM=RUN, total_bits=0.
  - Outputs: out_valid=0, out_last=0, flush_done=0, in_ready=1 after the reset edge.
  - Reset mid-operation discards all buffered bits and any pending flush.
- Input and accept:
  - in_ready = (FSM==RUN) && (fill < WORD_W). It is combinational from registers only and never depends on in_valid.
  - Accept = in_valid && in_ready. On accept, the low len bits of code_value are appended below the existing fill, fill += len, and total_bits += len.
  - Bits of code_value above len are ignored.
  - len=0 is accepted and is a no-op apart from the handshake.
  - A non-contiguous mask is a caller error and the result is undefined; the bench does not drive it.
- Output word:
  - out_valid = (fill >= WORD_W) || (FSM==FLUSH && fill > 0).
  - out_data = acc[top WORD_W bits]; bits beyond fill read 0.
  - out_nbits = min(fill, WORD_W).
  - out_last = (FSM==FLUSH) && (fill <= WORD_W) && out_valid.
- Pop:
  - Pop = out_valid && out_ready. On pop, acc shifts left by WORD_W with zero fill, and fill -= out_nbits.
  - While out_valid && !out_ready, out_data, out_nbits and out_last hold stable.
- Latency:
  - An accepted code appears in the output state the next cycle.
  - A full word is presented the cycle after fill reaches WORD_W.
- No simultaneous accept/pop:
  - A full-word pop requires fill >= WORD_W, where in_ready=0.
  - A flush pop occurs only in FLUSH, where in_ready=0.
  - At most one state update per cycle, so there is no need for combined arithmetic.
- FSM transitions:
  - RUN -> FLUSH when flush=1 at an edge. A code accepted in the same cycle is included before the flush.
  - FLUSH -> DONE when fill==0: immediately if nothing is buffered, otherwise the cycle after the out_last pop.
  - FLUSH with fill > WORD_W first emits the full words (out_last=0), then the partial word.
  - DONE: flush_done=1 for exactly one cycle, in_ready=0, then -> RUN.
  - flush asserted while in FLUSH or DONE is ignored.
- Width rules:
  - Maximum fill is WORD_W-1+MAX_CODE_W, which can never overflow acc.
  - total_bits wraps silently.

Test Plan:
- Reset, WORD_W=16: hold rst_n=0 for 2 cycles -> out_valid=0, in_ready=1, total_bits=0, flush_done=0.
- WORD_W=8, continuous out_ready=1:
  - Codes (value,mask) = (0x5,0x7), (0x1,0x3), (0x6,0x7), (0x1,0x1) -> one word out_data=0xAE, out_nbits=8.
  - Then pulse flush -> out_data=0x80, out_nbits=1, out_last=1.
  - flush_done pulses the next cycle; total_bits=9.
- Backpressure, WORD_W=16:
  - Two 15-bit codes 0x7FFF with out_ready=0 -> fill=30, in_ready=0, out_data=0xFFFF held for 10 cycles.
  - Raise out_ready -> one pop, fill=14, in_ready=1; no bits lost or duplicated.
- Zero-length code: mask=0x0000, value=0x7FFF -> accepted (in_ready=1), fill and total_bits unchanged, out_valid stays 0.
- Flush with empty buffer, plus flush during accept:
  - flush at fill=0 -> no out_valid, flush_done one cycle later.
  - flush with an accept of (0x3,0x3) in the same cycle -> partial word 0xC000, out_nbits=2, out_last=1.
- Reset mid-stream: fill=10, FSM=FLUSH, rst_n=0 one cycle -> out_valid=0, fill=0, FSM=RUN, no flush_done pulse.
